sort3_pipelined: RTL and testbench

Pipelined three-input sorter for the median-filter datapath. Each cycle it accepts three unsigned samples (one column/row triple of the 3x3 window) and, a fixed number of cycles later, presents them ordered as maximum, median and minimum. Downstream median-of-nine logic cascades several instances of this block. The block is fully pipelined, accepts one triple per clock, and tags every result with a `done` strobe.

---
 rtl/sort3_pipelined.sv | 84 ++++++++
 tb/tb_sort3_pipelined.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sort3_pipelined.sv
// Three-input unsigned sorter (max/med/min) built from three compare-exchange stages.
// Latency: a triple sampled at edge N is presented after edge N+2 with done high for one cycle.
// No backpressure: accepts one triple per clock whenever en is high; results are never stalled.
module sort3_pipelined #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] S1,
    input  logic [DATA_WIDTH-1:0] S2,
    input  logic [DATA_WIDTH-1:0] S3,
    output logic [DATA_WIDTH-1:0] max,
    output logic [DATA_WIDTH-1:0] med,
    output logic [DATA_WIDTH-1:0] min,
    output logic                  done
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] hi;
        logic [DATA_WIDTH-1:0] c;
    } st1_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] mid;
        logic [DATA_WIDTH-1:0] mx;
    } st2_t;

    st1_t st1_dat, st1_nxt;
    st2_t st2_dat, st2_nxt;
    logic st1_vld, st2_vld;

    always_comb begin
        st1_nxt.lo  = (S1 < S2) ? S1 : S2;
        st1_nxt.hi  = (S1 < S2) ? S2 : S1;
        st1_nxt.c   = S3;

        st2_nxt.lo  = st1_dat.lo;
        st2_nxt.mx  = (st1_dat.hi < st1_dat.c) ? st1_dat.c  : st1_dat.hi;
        st2_nxt.mid = (st1_dat.hi < st1_dat.c) ? st1_dat.hi : st1_dat.c;
    end

    // Valid bits always follow upstream; data registers hold unless fresh data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_vld <= 1'b0;
            st1_dat <= '0;
        end else begin
            st1_vld <= en;
            if (en)
                st1_dat <= st1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st2_vld <= 1'b0;
            st2_dat <= '0;
        end else begin
            st2_vld <= st1_vld;
            if (st1_vld)
                st2_dat <= st2_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            max  <= '0;
            med  <= '0;
            min  <= '0;
        end else begin
            done <= st2_vld;
            if (st2_vld) begin
                max <= st2_dat.mx;
                med <= (st2_dat.lo < st2_dat.mid) ? st2_dat.mid : st2_dat.lo;
                min <= (st2_dat.lo < st2_dat.mid) ? st2_dat.lo  : st2_dat.mid;
            end
        end
    end

endmodule

// File: tb/tb_sort3_pipelined.sv
// Bench for sort3_pipelined: directed orders, ties, sweeps, gaps, async reset and random streams.
// Expected results come from a history queue of sorted triples delayed by three edges.
module tb_sort3_pipelined;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] S1, S2, S3;
    logic [7:0] max, med, min;
    logic       done;

    int tests;
    int fails;

    typedef struct {
        bit       v;
        int       mn;
        int       md;
        int       mx;
    } ent_t;

    ent_t hist[$];
    int   held_mn, held_md, held_mx;

    sort3_pipelined #(.DATA_WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .S1   (S1),
        .S2   (S2),
        .S3   (S3),
        .max  (max),
        .med  (med),
        .min  (min),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sort by plain arithmetic: median is the sum minus the two extremes.
    function automatic ent_t sorted(input bit v, input int a, input int b, input int c);
        ent_t r;
        int lo, hi;
        lo = a; if (b < lo) lo = b; if (c < lo) lo = c;
        hi = a; if (b > hi) hi = b; if (c > hi) hi = c;
        r.v  = v;
        r.mn = lo;
        r.mx = hi;
        r.md = a + b + c - lo - hi;
        return r;
    endfunction

    task automatic step(input string tag, input bit e, input int a, input int b, input int c);
        int exp_done;
        en = e;
        S1 = a[7:0];
        S2 = b[7:0];
        S3 = c[7:0];
        @(posedge clk);
        #1;
        hist.push_back(sorted(e, a, b, c));
        exp_done = 0;
        if (hist.size() >= 3 && hist[hist.size()-3].v) begin
            exp_done = 1;
            held_mn  = hist[hist.size()-3].mn;
            held_md  = hist[hist.size()-3].md;
            held_mx  = hist[hist.size()-3].mx;
        end
        while (hist.size() > 3) void'(hist.pop_front());
        chk({tag, ".done"}, int'(done), exp_done);
        chk({tag, ".min"},  int'(min),  held_mn);
        chk({tag, ".med"},  int'(med),  held_md);
        chk({tag, ".max"},  int'(max),  held_mx);
    endtask

    task automatic directed(input string tag, input int a, input int b, input int c,
                            input int emn, input int emd, input int emx);
        step(tag, 1'b1, a, b, c);
        step(tag, 1'b0, 0, 0, 0);
        step(tag, 1'b0, 0, 0, 0);
        chk({tag, ".cmin"}, int'(min), emn);
        chk({tag, ".cmed"}, int'(med), emd);
        chk({tag, ".cmax"}, int'(max), emx);
        chk({tag, ".cdone"}, int'(done), 1);
        step(tag, 1'b0, 0, 0, 0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        held_mn = 0;
        held_md = 0;
        held_mx = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        S1      = 8'd11;
        S2      = 8'd22;
        S3      = 8'd33;
        repeat (3) @(posedge clk);
        #2;
        chk("reset.done", int'(done), 0);
        chk("reset.min",  int'(min),  0);
        chk("reset.med",  int'(med),  0);
        chk("reset.max",  int'(max),  0);
        en    = 1'b0;
        rst_n = 1'b1;

        directed("ord_a", 10, 20, 15, 10, 15, 20);
        directed("ord_b", 50, 30, 40, 30, 40, 50);
        directed("ord_c", 5, 25, 15, 5, 15, 25);
        directed("tie_a", 7, 7, 3, 3, 7, 7);
        directed("tie_b", 9, 9, 9, 9, 9, 9);
        directed("ext_a", 255, 0, 128, 0, 128, 255);
        directed("ext_b", 0, 255, 255, 0, 255, 255);

        step("perm", 1'b1, 1, 2, 3);
        step("perm", 1'b1, 1, 3, 2);
        step("perm", 1'b1, 2, 1, 3);
        step("perm", 1'b1, 2, 3, 1);
        step("perm", 1'b1, 3, 1, 2);
        step("perm", 1'b1, 3, 2, 1);
        repeat (3) step("perm_flush", 1'b0, 0, 0, 0);

        step("gap", 1'b1, 10, 20, 15);
        step("gap", 1'b0, 99, 98, 97);
        step("gap", 1'b1, 50, 30, 40);
        step("gap", 1'b1, 5, 25, 15);
        repeat (3) step("gap_flush", 1'b0, 0, 0, 0);

        step("rst_mid", 1'b1, 50, 30, 40);
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async.done", int'(done), 0);
        chk("rst_async.min",  int'(min),  0);
        chk("rst_async.med",  int'(med),  0);
        chk("rst_async.max",  int'(max),  0);
        hist.delete();
        held_mn = 0;
        held_md = 0;
        held_mx = 0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_en_ignored.done", int'(done), 0);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (6) step("post_rst", 1'b0, 0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            step("rand", bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)));
        end
        repeat (3) step("rand_flush", 1'b0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
